// File: rtl/plus_irq_responder.sv
// plus_irq_responder
// Interrupt responder for the Plus ASIC. It tracks the raster line, collects
// raster and DMA end-of-list interrupts into pending bits, drives the Z80
// /INT line and supplies an IM2 vector during the interrupt acknowledge cycle.

module plus_irq_responder #(
   parameter logic [7:0] IVR_RESET = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hsync_i,
   input  logic        vsync_i,
   input  logic        int_enable,
   input  logic        rmr2_active,
   input  logic        mem_wr,
   input  logic        mem_rd,
   input  logic [15:0] mem_a,
   input  logic [7:0]  mem_d,
   input  logic [2:0]  dma_irq,
   input  logic        cpu_ack,
   output logic [7:0]  rd_data,
   output logic        rd_hit,
   output logic [7:0]  vec_o,
   output logic        vec_oe,
   output logic        int_n
);

   // Register page addresses inside the 0x4000-0x7FFF ASIC window
   localparam logic [15:0] AddrPri  = 16'h6800;
   localparam logic [15:0] AddrIvr  = 16'h6805;
   localparam logic [15:0] AddrDcsr = 16'h6C0F;

   // Acknowledge FSM states
   localparam logic [1:0] StateIdle = 2'd0;
   localparam logic [1:0] StateAck  = 2'd1;
   localparam logic [1:0] StateWait = 2'd2;

   // Source codes placed in vector bits [2:1]
   localparam logic [1:0] SrcRaster = 2'b11;
   localparam logic [1:0] SrcDma0   = 2'b10;
   localparam logic [1:0] SrcDma1   = 2'b01;
   localparam logic [1:0] SrcDma2   = 2'b00;

   // Edge-detect history
   logic       memWrPrev_q;
   logic       hsyncPrev_q;
   logic       vsyncPrev_q;
   logic       cpuAckPrev_q;

   // Programmable registers
   logic [7:0] pri_q;
   logic [7:0] pri_d;
   logic [7:0] ivr_q;
   logic [7:0] ivr_d;

   // Raster line tracking
   logic [7:0] lineCnt_q;
   logic [7:0] lineCnt_d;
   logic [7:0] lineInc;
   logic       rasterHit_q;
   logic       rasterHit_d;

   // Pending interrupt sources
   logic       rasterPend_q;
   logic       rasterPend_d;
   logic [2:0] dmaPend_q;
   logic [2:0] dmaPend_d;

   // Acknowledge machinery and outputs
   logic [1:0] state_q;
   logic [1:0] state_d;
   logic [7:0] vec_q;
   logic [7:0] vec_d;
   logic       vecOe_q;
   logic       vecOe_d;
   logic       intN_q;
   logic       intN_d;

   // Decoded events
   logic       wrStrobe;
   logic       wrPri;
   logic       wrIvr;
   logic       wrDcsr;
   logic       hsyncFall;
   logic       vsyncRise;
   logic       ackRise;
   logic       ackStart;
   logic       anyPending;
   logic [1:0] ackSrc;
   logic       rasterAckClr;
   logic [2:0] dmaAckClr;
   logic [2:0] dcsrClr;

   // Edge detection and write strobe decode for the CPU and video inputs
   always_comb begin
      wrStrobe  = mem_wr & ~memWrPrev_q & rmr2_active;
      wrPri     = wrStrobe & (mem_a == AddrPri);
      wrIvr     = wrStrobe & (mem_a == AddrIvr);
      wrDcsr    = wrStrobe & (mem_a == AddrDcsr);
      hsyncFall = ~hsync_i & hsyncPrev_q;
      vsyncRise = vsync_i & ~vsyncPrev_q;
      ackRise   = cpu_ack & ~cpuAckPrev_q;
   end

   // Register writes take effect on the strobe edge; a latched vector is unaffected
   always_comb begin
      pri_d = pri_q;
      ivr_d = ivr_q;
      if (wrPri) begin
         pri_d = mem_d;
      end
      if (wrIvr) begin
         ivr_d = mem_d;
      end
   end

   // Line counter: vsync clears, hsync falling edge counts, match flagged one stage later
   always_comb begin
      lineInc     = lineCnt_q + 8'd1;
      lineCnt_d   = lineCnt_q;
      rasterHit_d = 1'b0;
      if (vsyncRise) begin
         lineCnt_d = 8'd0;
      end else if (hsyncFall) begin
         lineCnt_d   = lineInc;
         rasterHit_d = (lineInc == pri_q) && (pri_q != 8'd0);
      end
   end

   // Highest-priority pending source: raster, then DMA0, DMA1, DMA2
   always_comb begin
      anyPending = rasterPend_q | (|dmaPend_q);
      if (rasterPend_q) begin
         ackSrc = SrcRaster;
      end else if (dmaPend_q[0]) begin
         ackSrc = SrcDma0;
      end else if (dmaPend_q[1]) begin
         ackSrc = SrcDma1;
      end else if (dmaPend_q[2]) begin
         ackSrc = SrcDma2;
      end else begin
         ackSrc = SrcRaster;
      end
   end

   // Pending bit update: DCSR and acknowledge clear, new events set, and a set wins a tie
   always_comb begin
      ackStart     = (state_q == StateIdle) & ackRise;
      rasterAckClr = ackStart & rasterPend_q;
      dmaAckClr    = 3'b000;
      if (ackStart && !rasterPend_q && ivr_q[0]) begin
         case (ackSrc)
            SrcDma0: dmaAckClr = {2'b00, dmaPend_q[0]};
            SrcDma1: dmaAckClr = {1'b0, dmaPend_q[1], 1'b0};
            SrcDma2: dmaAckClr = {dmaPend_q[2], 2'b00};
            default: dmaAckClr = 3'b000;
         endcase
      end
      dcsrClr      = wrDcsr ? mem_d[6:4] : 3'b000;
      dmaPend_d    = (dmaPend_q & ~(dcsrClr | dmaAckClr)) | dma_irq;
      rasterPend_d = (rasterPend_q & ~rasterAckClr) | rasterHit_q;
   end

   // Acknowledge FSM: latch vector on the ack rising edge, hold it until ack drops
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      vecOe_d = vecOe_q;
      case (state_q)
         StateIdle: begin
            vec_d   = 8'h00;
            vecOe_d = 1'b0;
            if (ackRise) begin
               state_d = StateAck;
               vec_d   = {ivr_q[7:3], ackSrc, 1'b0};
               vecOe_d = 1'b1;
            end
         end
         StateAck: begin
            state_d = StateWait;
         end
         StateWait: begin
            if (!cpu_ack) begin
               state_d = StateIdle;
               vec_d   = 8'h00;
               vecOe_d = 1'b0;
            end
         end
         default: begin
            state_d = StateIdle;
            vec_d   = 8'h00;
            vecOe_d = 1'b0;
         end
      endcase
   end

   // Interrupt request is the gated OR of all pending bits, registered
   always_comb begin
      intN_d = ~((rasterPend_q | (|dmaPend_q)) & int_enable);
   end

   // DCSR read-back path is purely combinational
   always_comb begin
      rd_hit  = mem_rd & rmr2_active & (mem_a == AddrDcsr);
      rd_data = rd_hit ? {rasterPend_q, dmaPend_q, 4'b0000} : 8'h00;
   end

   // State registers; edge history reloads from the live inputs during reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         memWrPrev_q  <= mem_wr;
         hsyncPrev_q  <= hsync_i;
         vsyncPrev_q  <= vsync_i;
         cpuAckPrev_q <= cpu_ack;
         pri_q        <= 8'h00;
         ivr_q        <= IVR_RESET;
         lineCnt_q    <= 8'h00;
         rasterHit_q  <= 1'b0;
         rasterPend_q <= 1'b0;
         dmaPend_q    <= 3'b000;
         state_q      <= StateIdle;
         vec_q        <= 8'h00;
         vecOe_q      <= 1'b0;
         intN_q       <= 1'b1;
      end else begin
         memWrPrev_q  <= mem_wr;
         hsyncPrev_q  <= hsync_i;
         vsyncPrev_q  <= vsync_i;
         cpuAckPrev_q <= cpu_ack;
         pri_q        <= pri_d;
         ivr_q        <= ivr_d;
         lineCnt_q    <= lineCnt_d;
         rasterHit_q  <= rasterHit_d;
         rasterPend_q <= rasterPend_d;
         dmaPend_q    <= dmaPend_d;
         state_q      <= state_d;
         vec_q        <= vec_d;
         vecOe_q      <= vecOe_d;
         intN_q       <= intN_d;
      end
   end

   assign vec_o  = vec_q;
   assign vec_oe = vecOe_q;
   assign int_n  = intN_q;

endmodule
